output_data: RTL and testbench

- Write-side counterpart of the button capture path: the processor writes per-channel commands, and the block drives NUM_OUTPUTS physical outputs (LEDs, robot enable lines).
- Each channel independently holds a mode: off, on, blink, or a timed one-shot pulse.
- A 32-bit status word returns per-channel busy flags, zero-extended, in the same format as the button capture word.
- Sits between the processor register bus and the board output pins.

---
 rtl/output_pkg.sv | 16 +
 rtl/output_channel.sv | 118 +++++++++++
 rtl/output_data.sv | 43 ++++
 tb/tb_output_data.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/output_pkg.sv
// Shared command-mode encodings and channel state type for the output driver.
package output_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_BLINK = 2'd2,
    S_PULSE = 2'd3
  } chan_state_e;

endpackage

// File: rtl/output_channel.sv
// One output channel: mode FSM, per-channel prescaler, stored half-period and tick down-counter.
//
// state   | meaning
// S_OFF   | output low, prescaler idle
// S_ON    | output held high, prescaler idle
// S_BLINK | output toggles every stored half-period, runs until overridden
// S_PULSE | output high until the tick counter reaches terminal count (busy)
module output_channel
  import output_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [1:0]           mode,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 out,
  output logic                 busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  chan_state_e          state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 out_q, out_d;
  logic                 running;
  logic                 tick;

  assign running = (state_q == S_BLINK) || (state_q == S_PULSE);
  assign tick    = running && (presc_q == PRESC_MAX);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    out_d   = out_q;

    if (load) begin
      // A command always restarts timing; any coincident tick is dropped.
      presc_d = '0;
      case (mode)
        MODE_ON: begin
          state_d = S_ON;
          out_d   = 1'b1;
          cnt_d   = '0;
        end
        MODE_BLINK: begin
          state_d = S_BLINK;
          out_d   = 1'b1;
          len_d   = (length == '0) ? LEN_ONE : length;
          cnt_d   = (length == '0) ? LEN_ONE : length;
        end
        MODE_PULSE: begin
          len_d = length;
          if (length == '0) begin
            state_d = S_OFF;
            out_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = S_PULSE;
            out_d   = 1'b1;
            cnt_d   = length;
          end
        end
        default: begin
          state_d = S_OFF;
          out_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end else if (running) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (cnt_q <= LEN_ONE) begin
          if (state_q == S_PULSE) begin
            state_d = S_OFF;
            out_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            out_d = ~out_q;
            cnt_d = len_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end else begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_OFF;
      presc_q <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign busy = (state_q == S_PULSE);

endmodule

// File: rtl/output_data.sv
// Processor-written output driver: routes each command strobe to one channel and
// returns per-channel busy flags zero-extended to 32 bits.
module output_data
  import output_pkg::*;
#(
  parameter int NUM_OUTPUTS = 8,
  parameter int TICK_DIV    = 50000,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [4:0]             wr_channel,
  input  logic [1:0]             wr_mode,
  input  logic [LEN_WIDTH-1:0]   wr_length,
  output logic [NUM_OUTPUTS-1:0] out,
  output logic [31:0]            status
);

  logic [NUM_OUTPUTS-1:0] busy;

  // Out-of-range channel numbers match no instance and are silently dropped.
  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_chan
    output_channel #(
      .TICK_DIV  (TICK_DIV),
      .LEN_WIDTH (LEN_WIDTH)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .load   (wr_en && (wr_channel == 5'(i))),
      .mode   (wr_mode),
      .length (wr_length),
      .out    (out[i]),
      .busy   (busy[i])
    );
  end

  always_comb begin
    status = '0;
    status[NUM_OUTPUTS-1:0] = busy;
  end

endmodule

// File: tb/tb_output_data.sv
// Self-checking bench for output_data: constant vector table, directed timing
// sequences, and random commands checked against a cycle-count reference model.
module tb_output_data;

  localparam int NO = 8;
  localparam int TD = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_channel = '0;
  logic [1:0]    wr_mode = '0;
  logic [LW-1:0] wr_length = '0;
  logic [NO-1:0] out;
  logic [31:0]   status;

  int errors = 0;
  int checks = 0;

  output_data #(.NUM_OUTPUTS(NO), .TICK_DIV(TD), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_channel(wr_channel),
    .wr_mode(wr_mode), .wr_length(wr_length), .out(out), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        en;
    bit [4:0]  ch;
    bit [1:0]  mode;
    bit [15:0] len;
    int        wait_n;
    bit [7:0]  exp_out;
    bit [31:0] exp_status;
  } vec_t;

  vec_t vecs[13];

  // Reference model: mode per channel plus cycles elapsed since its last command.
  int m_mode[NO];
  int m_el[NO];
  int m_len[NO];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int ch, input int mode, input int len);
    wr_en = 1'b1;
    wr_channel = 5'(ch);
    wr_mode = 2'(mode);
    wr_length = LW'(len);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NO; i++) begin
      m_mode[i] = 0; m_el[i] = 0; m_len[i] = 0;
    end
  endfunction

  function automatic void model_step(input bit en, input int ch, input int mode, input int len);
    for (int i = 0; i < NO; i++) begin
      if (en && ch == i) begin
        m_el[i] = 0;
        m_mode[i] = mode;
        m_len[i] = (mode == 2 && len == 0) ? 1 : len;
        if (mode == 3 && len == 0) m_mode[i] = 0;
      end else if (m_mode[i] >= 2) begin
        m_el[i]++;
        if (m_mode[i] == 3 && m_el[i] == m_len[i] * TD) m_mode[i] = 0;
      end
    end
  endfunction

  function automatic logic [7:0] model_out();
    logic [7:0] r = '0;
    for (int i = 0; i < NO; i++) begin
      case (m_mode[i])
        1, 3:    r[i] = 1'b1;
        2:       r[i] = ((m_el[i] / (m_len[i] * TD)) % 2) == 0;
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] r = '0;
    for (int i = 0; i < NO; i++) r[i] = (m_mode[i] == 3);
    return r;
  endfunction

  initial begin
    //          en ch  mode len wait out    status
    vecs[0]  = '{1, 5, 1, 0, 0, 8'h20, 32'h0};
    vecs[1]  = '{1, 6, 1, 0, 0, 8'h60, 32'h0};
    vecs[2]  = '{1, 0, 3, 3, 0, 8'h61, 32'h1};
    vecs[3]  = '{1, 6, 0, 0, 0, 8'h21, 32'h1};
    vecs[4]  = '{1, 9, 1, 0, 0, 8'h21, 32'h1};
    vecs[5]  = '{1, 4, 3, 0, 0, 8'h21, 32'h1};
    vecs[6]  = '{1, 5, 0, 0, 7, 8'h01, 32'h1};
    vecs[7]  = '{1, 7, 1, 0, 0, 8'h80, 32'h0};
    vecs[8]  = '{1, 1, 2, 0, 3, 8'h82, 32'h0};
    vecs[9]  = '{0, 0, 0, 0, 0, 8'h80, 32'h0};
    vecs[10] = '{0, 0, 0, 0, 3, 8'h82, 32'h0};
    vecs[11] = '{1, 1, 0, 0, 0, 8'h80, 32'h0};
    vecs[12] = '{1, 7, 0, 0, 0, 8'h00, 32'h0};

    // Asynchronous reset in the middle of a pulse
    do_reset();
    check("reset_out", 32'(out), 32'h0);
    check("reset_status", status, 32'h0);
    send(2, 3, 5);
    idle(3);
    check("pre_reset_out", 32'(out), 32'h4);
    #2 rst = 1'b0;
    #1;
    check("async_reset_out", 32'(out), 32'h0);
    check("async_reset_status", status, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("post_reset_out", 32'(out), 32'h0);
      check("post_reset_status", status, 32'h0);
    end

    // Vector table
    for (int v = 0; v < 13; v++) begin
      if (vecs[v].en) send(int'(vecs[v].ch), int'(vecs[v].mode), int'(vecs[v].len));
      else idle(1);
      idle(vecs[v].wait_n);
      check($sformatf("vec%0d_out", v), 32'(out), 32'(vecs[v].exp_out));
      check($sformatf("vec%0d_status", v), status, vecs[v].exp_status);
    end

    // Blink ch1 half-period 2 ticks = 8 cycles, then OFF while high
    send(1, 2, 2);
    check("blink_k0", 32'(out[1]), 32'h1);
    for (int k = 1; k < 20; k++) begin
      idle(1);
      check($sformatf("blink_k%0d", k), 32'(out[1]), ((k / 8) % 2 == 0) ? 32'h1 : 32'h0);
      check("blink_status", status, 32'h0);
    end
    send(1, 0, 0);
    check("blink_off", 32'(out), 32'h0);

    // Pulse ch3 restarted mid-flight with a shorter width
    send(3, 3, 5);
    idle(5);
    check("restart_first", 32'(out), 32'h08);
    send(3, 3, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("restart_high%0d", k), 32'(out), 32'h08);
      check("restart_busy", status, 32'h08);
      idle(1);
    end
    check("restart_fall", 32'(out), 32'h0);
    check("restart_idle", status, 32'h0);

    // Random commands against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit en;
      int ch, md, ln;
      en = ($urandom_range(0, 9) == 0);
      ch = $urandom_range(0, 11);
      md = $urandom_range(0, 3);
      ln = $urandom_range(0, 4);
      wr_en = en;
      wr_channel = 5'(ch);
      wr_mode = 2'(md);
      wr_length = LW'(ln);
      model_step(en, ch, md, ln);
      @(posedge clk); #1;
      wr_en = 1'b0;
      check("rand_out", 32'(out), 32'(model_out()));
      check("rand_status", status, model_status());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
